// File: rtl/spi_flash_reader.sv
// SPI mode-0 master that issues a flash READ (0x03) and packs the returned
// bytes little-endian into 32-bit words written through the DRAM write port.
module spi_flash_reader #(
    parameter int CLK_DIV = 4,
    parameter int CS_HOLD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] flash_addr,
    input  logic [23:0] byte_count,
    input  logic [23:0] dram_base,
    output logic        busy,
    output logic        done,
    output logic        spi_cs,
    output logic        spi_clk,
    output logic        spi_si,
    input  logic        spi_so,
    output logic        dram_req,
    output logic [23:0] dram_addr,
    output logic        dram_we,
    output logic [31:0] dram_odata,
    input  logic        dram_ack
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_HOLD - 1);

    typedef enum logic [2:0] {IDLE, CMD, DATA, WR_WAIT, CS_GAP} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [4:0]        bit_cnt;
    logic [30:0]       cmd_sr;
    logic [7:0]        byte_sr;
    logic [31:0]       word_data;
    logic [31:0]       packed_word;
    logic [1:0]        byte_in_word;
    logic [23:0]       bytes_left;
    logic [23:0]       base_q;
    logic [21:0]       word_index;
    logic              phase_end;

    // Current word with the byte just completed dropped into its lane.
    always_comb begin
        packed_word = word_data;
        packed_word[{byte_in_word, 3'b000} +: 8] = byte_sr;
    end

    assign phase_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            spi_cs       <= 1'b1;
            spi_clk      <= 1'b0;
            spi_si       <= 1'b0;
            dram_req     <= 1'b0;
            dram_we      <= 1'b0;
            dram_addr    <= '0;
            dram_odata   <= '0;
            div_cnt      <= '0;
            gap_cnt      <= '0;
            bit_cnt      <= '0;
            cmd_sr       <= '0;
            byte_sr      <= '0;
            word_data    <= '0;
            byte_in_word <= '0;
            bytes_left   <= '0;
            base_q       <= '0;
            word_index   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Command MSB (bit 7 of 0x03) goes out immediately; the rest waits in cmd_sr.
                        cmd_sr       <= {7'h03, flash_addr};
                        bytes_left   <= byte_count;
                        base_q       <= dram_base;
                        word_index   <= '0;
                        word_data    <= '0;
                        byte_in_word <= '0;
                        bit_cnt      <= '0;
                        div_cnt      <= '0;
                        if (byte_count == 24'd0) begin
                            done <= 1'b1;
                        end else begin
                            busy   <= 1'b1;
                            spi_cs <= 1'b0;
                            spi_si <= 1'b0;
                            state  <= CMD;
                        end
                    end
                end

                CMD, DATA: begin
                    if (!phase_end) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!spi_clk) begin
                            spi_clk <= 1'b1;
                            if (state == DATA) begin
                                byte_sr <= {byte_sr[6:0], spi_so};
                            end
                        end else begin
                            spi_clk <= 1'b0;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (state == CMD) begin
                                spi_si <= cmd_sr[30];
                                cmd_sr <= {cmd_sr[29:0], 1'b0};
                                if (bit_cnt == 5'd31) begin
                                    state   <= DATA;
                                    bit_cnt <= '0;
                                    spi_si  <= 1'b0;
                                end
                            end else if (bit_cnt[2:0] == 3'd7) begin
                                bit_cnt    <= '0;
                                bytes_left <= bytes_left - 24'd1;
                                if (byte_in_word == 2'd3 || bytes_left == 24'd1) begin
                                    dram_req     <= 1'b1;
                                    dram_we      <= 1'b1;
                                    dram_addr    <= base_q + {2'b00, word_index};
                                    dram_odata   <= packed_word;
                                    word_data    <= '0;
                                    byte_in_word <= '0;
                                    state        <= WR_WAIT;
                                end else begin
                                    word_data    <= packed_word;
                                    byte_in_word <= byte_in_word + 2'd1;
                                end
                            end
                        end
                    end
                end

                WR_WAIT: begin
                    if (dram_ack) begin
                        dram_req   <= 1'b0;
                        dram_we    <= 1'b0;
                        word_index <= word_index + 22'd1;
                        div_cnt    <= '0;
                        if (bytes_left != 24'd0) begin
                            state <= DATA;
                        end else begin
                            state   <= CS_GAP;
                            spi_cs  <= 1'b1;
                            gap_cnt <= '0;
                        end
                    end
                end

                CS_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
